mem_dma: RTL
============

MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 15'h1000, lowest writable address (below it is write-protected BIOS/font ROM).
REQ-002 SHALL have parameter TOP_ADD, default 15'h7FFF, highest RAM address.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only while idle.
REQ-006 mode  input  1  0 = copy src->dst, 1 = fill dst with fill_data.
REQ-007 src / dst / len  input  15 each  source address, destination address, byte count.
REQ-008 fill_data  input  8  fill byte for mode 1.
REQ-009 bus_grant  input  1  arbiter grant; high = engine may drive the RAM port this cycle.
REQ-010 busy  output  1  transfer in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  request rejected; sticky until next accepted start.
REQ-013 ram_add  output  15  RAM address.
REQ-014 ram_wdata  output  8  RAM write data.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 ram_rdata  input  8  RAM read data, valid the cycle after the address was presented (1-cycle synchronous read).

Function
REQ-017 States SHALL be IDLE, CHECK, READ, WRITE, DONE.
REQ-018 IDLE: start=1 latches src, dst, len, mode, fill_data into working registers, clears err, goes to CHECK; start while not IDLE SHALL be ignored.
REQ-019 CHECK (1 cycle, no RAM access): len=0 -> DONE, no access, err=0; dst<ROM_SIZE, dst+len-1>TOP_ADD, or (mode 0 and src+len-1>TOP_ADD) -> err=1, DONE, no writes; otherwise READ (mode 0) or WRITE (mode 1). Range sums SHALL be computed 16 bits wide.
REQ-020 READ: when bus_grant=1, ram_add=src, ram_we=0, next state WRITE; when bus_grant=0, hold.
REQ-021 WRITE: when bus_grant=1, ram_add=dst, ram_we=1, ram_wdata = fill_data (mode 1) or copy byte (mode 0); dst+1, len-1, src+1 in mode 0; len reaching 0 -> DONE, else READ (mode 0) or stay in WRITE (mode 1). When bus_grant=0, hold with ram_we=0.
REQ-022 Copy byte: on the cycle immediately after a READ access, ram_rdata SHALL be registered into a hold register regardless of bus_grant; a WRITE in that same cycle SHALL drive ram_rdata directly, a later WRITE SHALL drive the hold register.
REQ-023 ram_we SHALL be 1 only in WRITE with bus_grant=1, and never with ram_add<ROM_SIZE.
REQ-024 Copy SHALL run ascending; overlapping ranges follow forward order (dst=src+1 replicates byte src).
REQ-025 DONE: done=1, busy=0 for one cycle, then IDLE. busy=1 in CHECK, READ, WRITE only.
REQ-026 Latency with bus_grant=1 throughout, start sampled at edge k: copy of N bytes -> writes at cycles k+3, k+5, ..., k+1+2N, done at k+2+2N; fill -> writes at k+2..k+1+N, done at k+2+N; error/len=0 -> done at k+2.
REQ-027 Outside READ/WRITE with grant, ram_add SHALL hold its last value, ram_we=0, ram_wdata=0.

Reset
REQ-028 reset=1 SHALL force IDLE, busy=0, done=0, err=0, ram_we=0, ram_add=0, ram_wdata=0 on the next edge, including mid-transfer; the partially written range is not rolled back.
REQ-029 start asserted together with reset SHALL be ignored.

Verification
REQ-030 Fill dst=15'h1000, len=4, fill_data=8'hAA, grant=1 -> writes AA to 1000..1003 at k+2..k+5, done at k+6, err=0.
REQ-031 Copy src=15'h0900, dst=15'h2000, len=3 -> 2000..2002 equal font bytes 0900..0902, one write every 2 cycles, done at k+8.
REQ-032 Fill dst=15'h0FFF, len=2 -> err=1, done at k+2, no ram_we; err stays 1 until next start.
REQ-033 Copy src=15'h7FFE, dst=15'h3000, len=3 -> err=1, no writes; len=0 request -> done at k+2, err=0, no access.
REQ-034 Copy len=4 with bus_grant dropped for 3 cycles right after the second READ -> correct data at all 4 destinations, ram_we=0 during stall, done delayed 3 cycles.
REQ-035 Fill len=100 with reset asserted after 10 writes -> next edge ram_we=0, busy=0; following start accepted normally.

Source files
------------

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dma
//  Brief    : Single-port RAM copy/fill engine with ROM write protection and
//             arbiter-granted bus access.
//  Revision : 1.0
// ============================================================================
module mem_dma #(
    parameter logic [14:0] ROM_SIZE = 15'h1000,
    parameter logic [14:0] TOP_ADD  = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [14:0] src,
    input  logic [14:0] dst,
    input  logic [14:0] len,
    input  logic [7:0]  fill_data,
    input  logic        bus_grant,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [14:0] ram_add,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [14:0] r_src;
    logic [14:0] r_dst;
    logic [14:0] r_len;
    logic        r_mode;
    logic [7:0]  r_fill;
    logic        r_err;
    logic [7:0]  r_hold;
    logic        r_rd_pend;
    logic [14:0] r_last_add;

    logic        w_rd_acc;
    logic        w_wr_go;
    logic [15:0] w_dst_end;
    logic [15:0] w_src_end;
    logic        w_range_err;
    logic [7:0]  w_copy_byte;

    assign w_rd_acc  = (r_state == S_READ)  && bus_grant;
    assign w_wr_go   = (r_state == S_WRITE) && bus_grant;

    // End addresses carry an extra bit so a range running past 7FFF is seen.
    assign w_dst_end = {1'b0, r_dst} + {1'b0, r_len} - 16'd1;
    assign w_src_end = {1'b0, r_src} + {1'b0, r_len} - 16'd1;
    assign w_range_err = (r_dst < ROM_SIZE) ||
                         (w_dst_end > {1'b0, TOP_ADD}) ||
                         (!r_mode && (w_src_end > {1'b0, TOP_ADD}));

    // Read data is only live the cycle after the read; later writes use the hold copy.
    assign w_copy_byte = r_rd_pend ? ram_rdata : r_hold;

    assign ram_add   = w_rd_acc ? r_src : (w_wr_go ? r_dst : r_last_add);
    assign ram_we    = w_wr_go && (r_dst >= ROM_SIZE);
    assign ram_wdata = w_wr_go ? (r_mode ? r_fill : w_copy_byte) : 8'h00;

    assign busy = (r_state == S_CHECK) || (r_state == S_READ) || (r_state == S_WRITE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_mode     <= 1'b0;
            r_fill     <= '0;
            r_err      <= 1'b0;
            r_hold     <= '0;
            r_rd_pend  <= 1'b0;
            r_last_add <= '0;
        end else begin
            r_rd_pend <= w_rd_acc;
            if (r_rd_pend) begin
                r_hold <= ram_rdata;
            end
            if (w_rd_acc || w_wr_go) begin
                r_last_add <= ram_add;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= src;
                        r_dst   <= dst;
                        r_len   <= len;
                        r_mode  <= mode;
                        r_fill  <= fill_data;
                        r_err   <= 1'b0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_len == 15'd0) begin
                        r_state <= S_DONE;
                    end else if (w_range_err) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= r_mode ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    if (bus_grant) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus_grant) begin
                        r_dst <= r_dst + 15'd1;
                        r_len <= r_len - 15'd1;
                        if (!r_mode) begin
                            r_src <= r_src + 15'd1;
                        end
                        if (r_len == 15'd1) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= r_mode ? S_WRITE : S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
